// File: rtl/bus6502_pkg.sv
// Shared types for the 6502 bus-cycle initiator.
// Phase FSM states, cycle kinds and the latched cycle record.
package bus6502_pkg;

  typedef enum logic {
    PHI1,
    PHI2
  } phase_e;

  typedef enum logic [1:0] {
    CYC_IDLE,
    CYC_READ,
    CYC_WRITE
  } cyc_kind_e;

  localparam logic [15:0] IDLE_ADDR_DEF = 16'hFFFF;

  typedef struct packed {
    cyc_kind_e   kind;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } cycle_t;

  function automatic cycle_t idle_cycle(input logic [15:0] a);
    cycle_t c;
    c.kind  = CYC_IDLE;
    c.addr  = a;
    c.wdata = 8'h00;
    return c;
  endfunction

endpackage

// File: rtl/bus6502_initiator_phase_gen.sv
// Free-running phi1/phi2 phase generator.
// Emits phi2 plus first/last clk strobes of the current phase.
module bus6502_phase_gen
  import bus6502_pkg::*;
#(
  parameter int unsigned PHI1_CLKS = 4,
  parameter int unsigned PHI2_CLKS = 4
) (
  input  logic clk,
  input  logic rst,
  output logic phi2,
  output logic first_clk,
  output logic last_clk
);

  localparam int unsigned MAXC =
    (PHI1_CLKS > PHI2_CLKS) ? PHI1_CLKS : PHI2_CLKS;
  localparam int unsigned CW = $clog2(MAXC);

  phase_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] last_cnt;

  // Phase register and counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PHI1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Count out each phase, then flip and wrap the counter.
  always_comb begin
    last_cnt  = (state_q == PHI2) ? CW'(PHI2_CLKS - 1)
                                  : CW'(PHI1_CLKS - 1);
    phi2      = (state_q == PHI2);
    first_clk = (cnt_q == '0);
    last_clk  = (cnt_q == last_cnt);
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    if (last_clk) begin
      cnt_d   = '0;
      state_d = (state_q == PHI1) ? PHI2 : PHI1;
    end
  end

endmodule

// File: rtl/bus6502_initiator.sv
// 6502 bus-cycle initiator: CPU stand-in driving phi2/address/data.
// Host valid/ready requests become bus cycles; completions pulse rsp.
module bus6502_initiator
  import bus6502_pkg::*;
#(
  parameter int unsigned PHI1_CLKS    = 4,
  parameter int unsigned PHI2_CLKS    = 4,
  parameter int unsigned RESET_CYCLES = 8,
  parameter logic [15:0] IDLE_ADDR    = IDLE_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic        req_rwbar,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        phi2,
  output logic [15:0] address,
  output logic        rwbar,
  output logic [7:0]  data_out,
  input  logic [7:0]  data_in,
  output logic        data_oe,
  input  logic        rdy,
  output logic        res_n
);

  localparam int unsigned RCW = $clog2(RESET_CYCLES + 1);

  logic first_clk, last_clk;
  logic end_cyc, phi1_first, phi2_enter, stretch;

  cycle_t         cyc_q, cyc_d;
  logic [15:0]    address_q, address_d;
  logic           rwbar_q, rwbar_d;
  logic [7:0]     data_out_q, data_out_d;
  logic           data_oe_q, data_oe_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [7:0]     rsp_rdata_q, rsp_rdata_d;
  logic           res_n_q, res_n_d;
  logic [RCW-1:0] rst_cnt_q, rst_cnt_d;

  bus6502_phase_gen #(
    .PHI1_CLKS(PHI1_CLKS),
    .PHI2_CLKS(PHI2_CLKS)
  ) u_phase (
    .clk      (clk),
    .rst      (rst),
    .phi2     (phi2),
    .first_clk(first_clk),
    .last_clk (last_clk)
  );

  assign end_cyc    = phi2 && last_clk;
  assign phi1_first = !phi2 && first_clk;
  assign phi2_enter = !phi2 && last_clk;
  assign stretch    = (cyc_q.kind == CYC_READ) && !rdy;
  assign req_ready  = end_cyc && res_n_q && !stretch;

  assign address   = address_q;
  assign rwbar     = rwbar_q;
  assign data_out  = data_out_q;
  assign data_oe   = data_oe_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign res_n     = res_n_q;

  // Bus-side and host-side state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q       <= idle_cycle(IDLE_ADDR);
      address_q   <= IDLE_ADDR;
      rwbar_q     <= 1'b1;
      data_out_q  <= 8'h00;
      data_oe_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      res_n_q     <= 1'b0;
      rst_cnt_q   <= '0;
    end else begin
      cyc_q       <= cyc_d;
      address_q   <= address_d;
      rwbar_q     <= rwbar_d;
      data_out_q  <= data_out_d;
      data_oe_q   <= data_oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      res_n_q     <= res_n_d;
      rst_cnt_q   <= rst_cnt_d;
    end
  end

  // Cycle selection, completion, bus drive timing and reset count.
  always_comb begin
    cyc_d       = cyc_q;
    address_d   = address_q;
    rwbar_d     = rwbar_q;
    data_out_d  = data_out_q;
    data_oe_d   = data_oe_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    res_n_d     = res_n_q;
    rst_cnt_d   = rst_cnt_q;

    if (end_cyc) begin
      unique case (1'b1)
        stretch: ;
        req_valid && req_ready: begin
          cyc_d.kind  = req_rwbar ? CYC_READ : CYC_WRITE;
          cyc_d.addr  = req_addr;
          cyc_d.wdata = req_wdata;
        end
        default: cyc_d = idle_cycle(IDLE_ADDR);
      endcase
      if (cyc_q.kind == CYC_READ && rdy) begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = data_in;
      end
      if (cyc_q.kind == CYC_WRITE) begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = 8'h00;
      end
      if (!res_n_q) begin
        rst_cnt_d = rst_cnt_q + 1'b1;
        res_n_d   = (rst_cnt_q == RCW'(RESET_CYCLES - 1));
      end
    end

    if (phi1_first) begin
      address_d = cyc_q.addr;
      rwbar_d   = (cyc_q.kind != CYC_WRITE);
      data_oe_d = 1'b0;
      if (cyc_q.kind == CYC_WRITE) begin
        data_out_d = cyc_q.wdata;
      end
    end

    if (phi2_enter && cyc_q.kind == CYC_WRITE) begin
      data_oe_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_bus6502_initiator.sv
// Self-checking bench for bus6502_initiator.
// Bus-cycle reference model driven by directed and random steps.
module tb_bus6502_initiator;

  localparam int K_IDLE  = 0;
  localparam int K_READ  = 1;
  localparam int K_WRITE = 2;
  localparam int CYC     = 8;
  localparam int RST_CLKS = 64;

  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [7:0]  wd;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_addr = 16'h0;
  logic        req_rwbar = 1'b1;
  logic [7:0]  req_wdata = 8'h0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        phi2;
  logic [15:0] address;
  logic        rwbar;
  logic [7:0]  data_out;
  logic [7:0]  data_in = 8'h0;
  logic        data_oe;
  logic        rdy = 1'b1;
  logic        res_n;

  bus6502_initiator dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_rwbar(req_rwbar),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .phi2     (phi2),
    .address  (address),
    .rwbar    (rwbar),
    .data_out (data_out),
    .data_in  (data_in),
    .data_oe  (data_oe),
    .rdy      (rdy),
    .res_n    (res_n)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  int   t;
  bus_t cur, shown;
  int   prev_kind;
  logic exp_rsp_v;
  logic [7:0] last_rdata;
  bus_t q[$];
  logic rdy_force = 1'b0;
  logic rdy_val   = 1'b1;
  logic fix_en    = 1'b0;
  logic [7:0] fix_data = 8'h00;
  int   rsp_seen = 0;
  int   ready_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h t=%0d",
             tag, obs, exp_v, t);
    end
  endtask

  function automatic bus_t idle_bus();
    bus_t b;
    b.kind = K_IDLE;
    b.addr = 16'hFFFF;
    b.wd   = 8'h00;
    return b;
  endfunction

  task automatic model_reset();
    t          = 0;
    cur        = idle_bus();
    shown      = idle_bus();
    prev_kind  = K_IDLE;
    exp_rsp_v  = 1'b0;
    last_rdata = 8'h00;
  endtask

  task automatic push(input int k, input logic [15:0] a,
                      input logic [7:0] d);
    bus_t b;
    b.kind = k;
    b.addr = a;
    b.wd   = d;
    q.push_back(b);
  endtask

  // One clk period: drive, check, advance the bus-cycle model.
  task automatic tick();
    int   p;
    logic exp_ready;
    logic exp_oe;
    logic stall;
    p = t % CYC;
    if (q.size() > 0) begin
      req_valid = 1'b1;
      req_addr  = q[0].addr;
      req_rwbar = (q[0].kind == K_READ);
      req_wdata = q[0].wd;
    end else begin
      req_valid = 1'b0;
      req_addr  = 16'($urandom);
      req_rwbar = 1'($urandom);
      req_wdata = 8'($urandom);
    end
    data_in = fix_en ? fix_data : 8'($urandom);
    rdy     = rdy_force ? rdy_val : ($urandom_range(3) != 0);
    #1;
    if (p == 1) shown = cur;
    stall     = (cur.kind == K_READ) && !rdy;
    exp_ready = (p == CYC - 1) && (t >= RST_CLKS) && !stall;
    exp_oe    = (p >= CYC / 2 && cur.kind == K_WRITE) ||
                (p == 0 && prev_kind == K_WRITE);
    chk("phi2", 32'(phi2), 32'(p >= CYC / 2));
    chk("address", 32'(address), 32'(shown.addr));
    chk("rwbar", 32'(rwbar), 32'(shown.kind != K_WRITE));
    chk("data_oe", 32'(data_oe), 32'(exp_oe));
    if (exp_oe) chk("data_out", 32'(data_out), 32'(shown.wd));
    chk("res_n", 32'(res_n), 32'(t >= RST_CLKS));
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_v));
    chk("rsp_rdata", 32'(rsp_rdata), 32'(last_rdata));
    if (rsp_valid) rsp_seen++;
    if (req_ready) ready_seen++;
    exp_rsp_v = 1'b0;
    if (p == CYC - 1) begin
      if (cur.kind == K_READ && rdy) begin
        exp_rsp_v  = 1'b1;
        last_rdata = data_in;
      end
      if (cur.kind == K_WRITE) begin
        exp_rsp_v  = 1'b1;
        last_rdata = 8'h00;
      end
      prev_kind = cur.kind;
      if (!stall) begin
        if (exp_ready && req_valid) cur = q.pop_front();
        else cur = idle_bus();
      end
    end
    @(negedge clk);
    t++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int n;
    int r0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_phi2", 32'(phi2), 32'h0);
    chk("rst_res_n", 32'(res_n), 32'h0);
    chk("rst_addr", 32'(address), 32'hFFFF);
    chk("rst_oe", 32'(data_oe), 32'h0);
    chk("rst_dout", 32'(data_out), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    rst = 1'b0;
    model_reset();

    // Reset sequence with idle reads, rdy random.
    run(RST_CLKS + 8);

    // Idle cycles ignore rdy=0.
    rdy_force = 1'b1;
    rdy_val   = 1'b0;
    r0 = rsp_seen;
    run(16);
    chk("idle_no_rsp", 32'(rsp_seen - r0), 32'h0);
    rdy_val = 1'b1;

    // Directed read C000 -> A5.
    fix_en   = 1'b1;
    fix_data = 8'hA5;
    push(K_READ, 16'hC000, 8'h00);
    run(24);
    chk("read_rdata", 32'(rsp_rdata), 32'hA5);
    fix_en = 1'b0;

    // Directed write 8000 <- 3C.
    push(K_WRITE, 16'h8000, 8'h3C);
    r0 = rsp_seen;
    run(24);
    chk("write_rsp", 32'(rsp_seen - r0), 32'h1);
    chk("write_rdata", 32'(rsp_rdata), 32'h0);

    // rdy stretch on read FFFC for two cycles.
    push(K_READ, 16'hFFFC, 8'h00);
    n = 0;
    while (!(cur.kind == K_READ && cur.addr == 16'hFFFC) && n < 40) begin
      tick();
      n++;
    end
    chk("stretch_accept", 32'(n < 40), 32'h1);
    rdy_val = 1'b0;
    r0 = rsp_seen;
    n = ready_seen;
    run(16);
    chk("stretch_no_rsp", 32'(rsp_seen - r0), 32'h0);
    chk("stretch_no_ready", 32'(ready_seen - n), 32'h0);
    rdy_val = 1'b1;
    run(9);
    chk("stretch_one_rsp", 32'(rsp_seen - r0), 32'h1);

    // Back-to-back: three queued requests, one per bus cycle.
    push(K_READ, 16'h1234, 8'h00);
    push(K_WRITE, 16'h5678, 8'h99);
    push(K_READ, 16'h9ABC, 8'h00);
    r0 = rsp_seen;
    run(CYC * 3 + 2);
    chk("b2b_drained", 32'(q.size()), 32'h0);
    run(CYC * 2);
    chk("b2b_rsps", 32'(rsp_seen - r0), 32'h3);

    // Random traffic.
    rdy_force = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0 && $urandom_range(2) != 0)
        push($urandom_range(1) ? K_READ : K_WRITE,
             16'($urandom), 8'($urandom));
      run(CYC);
    end

    // Async reset mid-PHI2 of a write.
    push(K_WRITE, 16'h4321, 8'h5A);
    n = 0;
    while (!(cur.kind == K_WRITE && (t % CYC) == 5) && n < 60) begin
      tick();
      n++;
    end
    chk("wr_reach", 32'(n < 60), 32'h1);
    #2;
    chk("pre_oe", 32'(data_oe), 32'h1);
    rst = 1'b1;
    #1;
    chk("arst_phi2", 32'(phi2), 32'h0);
    chk("arst_oe", 32'(data_oe), 32'h0);
    chk("arst_res_n", 32'(res_n), 32'h0);
    chk("arst_addr", 32'(address), 32'hFFFF);
    chk("arst_rwbar", 32'(rwbar), 32'h1);
    q.delete();
    repeat (2) @(negedge clk);
    chk("arst_rsp", 32'(rsp_valid), 32'h0);
    rst = 1'b0;
    model_reset();
    run(RST_CLKS + 16);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
